// File: rtl/buffer_pkg.sv
// Shared constants and width helpers for the multi-channel buffer.
package buffer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CH     = 1;
  localparam int DEF_DEPTH  = 4;

  // Pointer width: enough bits to address DEPTH entries, never less than 1.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width: enough bits to hold 0..DEPTH, never less than 1.
  function automatic int cnt_w(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/buffer_mem.sv
// Storage array for mc_buffer: one write port, one asynchronous read port,
// contents cleared to zero by the asynchronous active-low reset.
module buffer_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming word on a push; reset zeroes every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mc_buffer.sv
// Multi-channel FIFO buffer: CH words of DATA_W bits move through one
// valid/ready handshake. Define BUFFER_LEVEL_EN to expose the occupancy on
// port o_level.
module mc_buffer
  import buffer_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CH       = DEF_CH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH*DATA_W-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 clear,
  output logic [CH*DATA_W-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_afull
`ifdef BUFFER_LEVEL_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] o_level
`endif
);

  localparam int PW    = ptr_w(DEPTH);
  localparam int CW    = cnt_w(DEPTH);
  localparam int WIDTH = CH * DATA_W;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Advance a pointer by one, wrapping at the last entry so DEPTH need not
  // be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake flags come only from the registered count, so there is no
  // combinational path from i_valid/i_ready to o_ready/o_valid.
  assign o_ready = (count != CW'(DEPTH));
  assign o_valid = (count != '0);
  assign o_afull = (int'(count) >= AF_LEVEL);
  assign push    = i_valid && o_ready && !clear;
  assign pop     = o_valid && i_ready && !clear;

  // Pointer and occupancy bookkeeping; clear wins over any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  buffer_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (i_data),
    .raddr (rd_ptr),
    .rdata (o_data)
  );

`ifdef BUFFER_LEVEL_EN
  assign o_level = count;
`endif

endmodule

// File: doc/mc_buffer.md
MC_BUFFER -- requirements
Module: mc_buffer

Interface
REQ-001 Parameter DATA_W, default 32: bit width of one channel word.
REQ-002 Parameter CH, default 1: number of parallel channels sharing one handshake; legal range 1..16.
REQ-003 Parameter DEPTH, default 4: number of storage entries; legal range 1..256, need not be a power of two.
REQ-004 Parameter AF_LEVEL, default DEPTH-1: occupancy at or above which o_afull is high.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 i_data  input  CH*DATA_W  write word; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 i_valid  input  1  write request.
REQ-009 o_ready  output  1  buffer accepts a write this cycle.
REQ-010 clear  input  1  synchronous flush of all contents and counters.
REQ-011 o_data  output  CH*DATA_W  head-of-buffer word, same channel packing as i_data.
REQ-012 o_valid  output  1  o_data holds a valid entry.
REQ-013 i_ready  input  1  downstream consumes the head entry when o_valid is also high.
REQ-014 o_afull  output  1  occupancy >= AF_LEVEL.
REQ-015 o_level  output  $clog2(DEPTH+1)  current occupancy; present only when BUFFER_LEVEL_EN is defined.

Function
REQ-016 Push occurs when i_valid && o_ready && !clear; pop occurs when o_valid && i_ready && !clear.
REQ-017 o_ready = (count != DEPTH); it depends only on registered state, never combinationally on i_valid or i_ready.
REQ-018 o_valid = (count != 0); o_data = entry at the read pointer, so the first-written word is the first read (strict FIFO order across all channels).
REQ-019 A write into an empty buffer appears on o_data/o_valid on the cycle after the push edge; there is no same-cycle bypass, so latency is 1 cycle.
REQ-020 Write and read pointers each increment by 1 per push or pop and wrap from DEPTH-1 to 0.
REQ-021 A simultaneous push and pop leaves count unchanged; when full, push is blocked by o_ready=0 even if a pop occurs in the same cycle.
REQ-022 When empty, i_ready has no effect and count does not underflow.
REQ-023 clear=1 sets count and both pointers to 0 on the next edge, and any push or pop that cycle is discarded; stored words need not be zeroed.
REQ-024 All CH channels are written and read together; there is no per-channel valid.

Reset
REQ-025 Asserting rst low immediately sets count, pointers, o_valid, o_afull (when AF_LEVEL>0) and o_level to 0, and sets o_ready to 1.
REQ-026 o_data reads 0 after reset until the first push, because storage resets to 0.
REQ-027 Reset asserted mid-stream discards all entries; the first push after release produces o_valid exactly 1 cycle later.

Configuration
REQ-028 Macro BUFFER_LEVEL_EN: when defined, port o_level exists and equals count every cycle.
REQ-029 When BUFFER_LEVEL_EN is not defined, o_level is absent, and count remains internal and still drives o_afull.

Structure
REQ-030 Package buffer_pkg holds the default DATA_W/CH/DEPTH constants and the pointer and count width functions, sized with a minimum of 1 bit.
REQ-031 Sub-module buffer_mem holds the DEPTH x (CH*DATA_W) storage: one write port, one asynchronous read port, and asynchronous active-low reset to 0.

Verification
REQ-032 Config DEPTH=4, CH=2, DATA_W=8: push 0x0201, 0x0403, 0x0605 with i_ready=1 -> the same words appear on o_data in order, each 1 cycle after its push.
REQ-033 DEPTH=4, i_ready=0: push 5 words -> o_ready drops after the 4th push, the 5th word is not accepted, and o_afull is high at count 3.
REQ-034 Full buffer, i_valid=1 and i_ready=1 for 10 cycles -> one word leaves per cycle, there are no drops or duplicates, and pointers wrap correctly (DEPTH=3 run also).
REQ-035 Buffer holding 2 entries, clear=1 together with i_valid=1 -> the next cycle shows o_valid=0 and o_ready=1, and the pushed word is absent.
REQ-036 rst pulsed low while 3 entries are held -> o_valid=0 immediately, then a push after release produces o_valid exactly 1 cycle later.
REQ-037 With BUFFER_LEVEL_EN defined, 100 random push/pop cycles -> o_level equals the scoreboard occupancy every cycle.
